// File: rtl/inverter_chain_freq_meter.sv
// Frequency meter: counts rising edges of one selected asynchronous oscillator tap over a gate window of clk cycles.
// Optional macro FREQ_METER_SAT_EN: the edge counter saturates at all-ones instead of wrapping.
module inverter_chain_freq_meter #(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 16,
  parameter int GATE_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_CH-1:0]         osc_in,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic [GATE_W-1:0]         gate_cycles,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT_W-1:0]        count,
  output logic                      valid,
  output logic                      overflow
);

  localparam int SEL_W = $clog2(NUM_CH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [SEL_W-1:0]   ch_lat;
  logic [SEL_W-1:0]   ch_pick;
  logic [GATE_W-1:0]  gate_cnt;
  logic [1:0]         arm_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] edge_cnt_next;
  logic               ovf_acc;
  logic               ovf_acc_next;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               edge_det;

  assign ch_pick  = (int'(ch_sel) < NUM_CH) ? ch_sel : '0;
  assign edge_det = s2 & ~s3;

  // The synchroniser runs continuously; the ARM cycles flush it after ch_lat changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in[ch_lat];
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    edge_cnt_next = edge_cnt;
    ovf_acc_next  = ovf_acc;
    if (state == S_COUNT && edge_det) begin
      if (&edge_cnt) begin
        ovf_acc_next = 1'b1;
`ifdef FREQ_METER_SAT_EN
        edge_cnt_next = edge_cnt;
`else
        edge_cnt_next = '0;
`endif
      end else begin
        edge_cnt_next = edge_cnt + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    if (!ena) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_next = S_ARM;
        S_ARM:   if (arm_cnt == 2'd2) state_next = (gate_cnt == '0) ? S_DONE : S_COUNT;
        S_COUNT: if (gate_cnt == GATE_W'(1)) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Results are loaded on entry to DONE so they appear together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch_lat   <= '0;
      gate_cnt <= '0;
      arm_cnt  <= '0;
      edge_cnt <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena && start) begin
            ch_lat   <= ch_pick;
            gate_cnt <= gate_cycles;
            arm_cnt  <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
          end
        end
        S_ARM: arm_cnt <= arm_cnt + 2'd1;
        S_COUNT: begin
          gate_cnt <= gate_cnt - GATE_W'(1);
          edge_cnt <= edge_cnt_next;
          ovf_acc  <= ovf_acc_next;
        end
        default: ;
      endcase
      if (state_next == S_DONE) begin
        done     <= 1'b1;
        valid    <= 1'b1;
        count    <= edge_cnt_next;
        overflow <= ovf_acc_next;
      end
    end
  end

endmodule

// File: tb/tb_inverter_chain_freq_meter.sv
// Bench for inverter_chain_freq_meter: random oscillator periods and windows checked every cycle against a
// timeline model that counts real oscillator rises inside the gate window, plus literal pinned cases.
`timescale 1ns/100ps
module tb_inverter_chain_freq_meter;
  localparam int NUM_CH  = 3;
  localparam int COUNT_W = 8;
  localparam int GATE_W  = 16;
  localparam int SEL_W   = $clog2(NUM_CH);
  localparam int MAXC    = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic start = 1'b0;
  logic [SEL_W-1:0] ch_sel = '0;
  logic [GATE_W-1:0] gate_cycles = '0;
  logic [NUM_CH-1:0] osc_hold = '0;
  wire  [NUM_CH-1:0] osc_in;
  logic busy, done, valid, overflow;
  logic [COUNT_W-1:0] count;

  int half_ns [NUM_CH] = '{20, 25, 30};
  int rises [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] osc_prev = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  int m_active = 0, m_T = 0, m_G = 0, m_ch = 0, m_snap0 = 0, m_snap1 = 0, m_n = 0;
  int exp_busy = 0, exp_done = 0, exp_valid = 0, exp_ovf = 0, exp_count = 0;

  inverter_chain_freq_meter #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .ch_sel(ch_sel),
    .gate_cycles(gate_cycles), .start(start), .busy(busy), .done(done),
    .count(count), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Oscillator edges sit on half-nanosecond times, so they never coincide with a clk edge.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_osc
    logic raw = 1'b0;
    initial begin
      #(2.5 + gi);
      forever begin
        raw = ~raw;
        #(half_ns[gi]);
      end
    end
    assign osc_in[gi] = raw & ~osc_hold[gi];
  end

  always @(osc_in) begin
    for (int i = 0; i < NUM_CH; i++) if (osc_in[i] && !osc_prev[i]) rises[i]++;
    osc_prev = osc_in;
  end

  // Timeline model: counted rises are those sampled at edges T+2..T+1+G, i.e. between edge T+1 and edge T+1+G.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; exp_busy = 0; exp_done = 0; exp_valid = 0; exp_ovf = 0; exp_count = 0;
    end else begin
      cyc++;
      exp_done = 0;
      if (!ena) begin
        m_active = 0;
      end else if (m_active != 0) begin
        if (cyc == m_T + 1) m_snap0 = rises[m_ch];
        if (cyc == m_T + 1 + m_G) m_snap1 = rises[m_ch];
        if (cyc == m_T + 3 + m_G) begin
          m_n = m_snap1 - m_snap0;
          exp_ovf = (m_n > MAXC) ? 1 : 0;
`ifdef FREQ_METER_SAT_EN
          exp_count = (m_n > MAXC) ? MAXC : m_n;
`else
          exp_count = m_n % (MAXC + 1);
`endif
          exp_done = 1;
          exp_valid = 1;
        end
        if (cyc == m_T + 4 + m_G) m_active = 0;
      end else if (start) begin
        m_active = 1;
        m_T = cyc;
        m_G = int'(gate_cycles);
        m_ch = (int'(ch_sel) < NUM_CH) ? int'(ch_sel) : 0;
      end
      exp_busy = m_active;
    end
  end

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", int'(busy), exp_busy);
      checkOutput("done", int'(done), exp_done);
      checkOutput("valid", int'(valid), exp_valid);
      checkOutput("count", int'(count), exp_count);
      checkOutput("overflow", int'(overflow), exp_ovf);
    end
  end

  task automatic waitIdle();
    int waited;
    waited = 0;
    while (busy && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_timeout", int'(busy), 0);
  endtask

  task automatic applyStimulus(input int ch, input int g, input bit chg_mid,
                               output int lat, output int cnt, output int ovf);
    waitIdle();
    ch_sel = SEL_W'(ch);
    gate_cycles = GATE_W'(g);
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    lat = -1; cnt = -1; ovf = -1;
    for (int i = 0; i < g + 20; i++) begin
      if (chg_mid && i == g / 2) ch_sel = SEL_W'($urandom_range(0, 3));
      if (done) begin
        lat = cyc + 1 - t0;
        cnt = int'(count);
        ovf = int'(overflow);
        break;
      end
      @(negedge clk);
    end
    checkOutput("done_latency", lat, g + 4);
  endtask

  initial begin
    int lat, cnt, ovf, ndone;
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lat, cnt, ovf, ndone;
    #23;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (3) @(negedge clk);

    // Period 4 clk over 100 cycles
    half_ns[2] = 20;
    applyStimulus(2, 100, 1'b0, lat, cnt, ovf);
    checkOutput("g100_count_24_to_26", int'(cnt >= 24 && cnt <= 26), 1);
    checkOutput("g100_overflow", ovf, 0);
    checkOutput("g100_valid", int'(valid), 1);

    // Silent channel, ch_sel changed mid-window
    osc_hold[1] = 1'b1;
    applyStimulus(1, 50, 1'b1, lat, cnt, ovf);
    checkOutput("silent_count", cnt, 0);
    osc_hold[1] = 1'b0;

    // Out-of-range select falls back to channel 0
    half_ns[0] = 20;
    applyStimulus(3, 100, 1'b0, lat, cnt, ovf);
    checkOutput("oor_count_24_to_26", int'(cnt >= 24 && cnt <= 26), 1);

    applyStimulus(2, 0, 1'b0, lat, cnt, ovf);
    checkOutput("g0_count", cnt, 0);

    // Start held high: one measurement per IDLE visit
    waitIdle();
    ch_sel = '0;
    gate_cycles = '0;
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    checkOutput("held_start_done_pulses", ndone, 2);

    // 500 rises into an 8-bit counter
    half_ns[2] = 20;
    applyStimulus(2, 2000, 1'b0, lat, cnt, ovf);
`ifdef FREQ_METER_SAT_EN
    checkOutput("ovf_sat_count", cnt, 255);
`else
    checkOutput("ovf_wrap_count_243_to_245", int'(cnt >= 243 && cnt <= 245), 1);
`endif
    checkOutput("ovf_flag", ovf, 1);

    // Abort by ena mid-window
    waitIdle();
    ch_sel = '0;
    gate_cycles = GATE_W'(200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
`ifdef FREQ_METER_SAT_EN
    checkOutput("abort_count_kept", int'(count), 255);
`else
    checkOutput("abort_count_kept", int'(count), 244);
`endif
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checkOutput("abort_no_done", ndone, 0);
    ena = 1'b1;

    // Randomised measurements
    for (int k = 0; k < 25; k++) begin
      for (int c = 0; c < NUM_CH; c++) half_ns[c] = int'($urandom_range(20, 70));
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 300)),
                    1'($urandom_range(0, 1)), lat, cnt, ovf);
    end

    // Asynchronous reset in the middle of a window
    waitIdle();
    ch_sel = 2'd2;
    gate_cycles = GATE_W'(200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_count", int'(count), 0);
    checkOutput("async_rst_valid", int'(valid), 0);
    checkOutput("async_rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    half_ns[2] = 20;
    applyStimulus(2, 100, 1'b0, lat, cnt, ovf);
    checkOutput("post_rst_count_24_to_26", int'(cnt >= 24 && cnt <= 26), 1);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
